// File: rtl/uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl
//   Sequencing FSM for the UART transmitter datapath. Accepts one byte per
//   valid/ready handshake, holds it for the whole frame and steps the output
//   mux select through start, data (LSB first), optional parity and stop.
//   Mux mapping: 00 = line high, 01 = start (0), 10 = data_bit, 11 = parity_bit.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   tx_valid   : requester has a byte on tx_data
//   tx_data    : byte to send, sampled only on accept
//   tx_ready   : high only in IDLE; accept = tx_valid & tx_ready
//   mux_sel    : select for the transmitter output mux
//   data_bit   : current data bit (shift register LSB)
//   parity_bit : parity of the latched byte
//   tx_busy    : high in every state except IDLE
//   tx_done    : one-cycle pulse in the last clk of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic [1:0]        mux_sel,
   output logic              data_bit,
   output logic              parity_bit,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] shift_reg;
   logic              accept;
   logic              bit_end;

   // tx_ready is a register that mirrors state == IDLE, so accept has no
   // combinational dependence on the FSM decode.
   assign accept   = tx_valid & tx_ready;
   assign bit_end  = (cnt == CNT_LAST);
   assign data_bit = shift_reg[0];

   function automatic logic [1:0] sel_of(input logic [2:0] s);
      case (s)
         S_START:  sel_of = 2'b01;
         S_DATA:   sel_of = 2'b10;
         S_PARITY: sel_of = 2'b11;
         default:  sel_of = 2'b00;
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept)  state_nxt = S_START;
         S_START:  if (bit_end) state_nxt = S_DATA;
         S_DATA:   if (bit_end && (idx == IDX_LAST))
                      state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (bit_end) state_nxt = S_STOP;
         S_STOP:   if (bit_end) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs are loaded from the next-state decode so they change
   // on the same edge as the state itself.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         mux_sel    <= 2'b00;
         tx_ready   <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         cnt        <= '0;
         idx        <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
      end else begin
         state    <= state_nxt;
         mux_sel  <= sel_of(state_nxt);
         tx_ready <= (state_nxt == S_IDLE);
         tx_busy  <= (state_nxt != S_IDLE);
         // Set one count early so the registered pulse lands on the
         // terminal-count cycle of the stop bit.
         tx_done  <= (state == S_STOP) && (cnt == CNT_PRE);

         if (state == S_IDLE) begin
            cnt <= '0;
            idx <= '0;
            if (accept) begin
               shift_reg  <= tx_data;
               parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
            end
         end else begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
            if ((state == S_DATA) && bit_end) begin
               shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
               idx       <= idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

   localparam int C = 16;
   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;

   logic [2:0] rdy, busy, done, dbit, pbit;
   logic [1:0] sel [3];

   always #5 clk = ~clk;

   uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_W(D), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(rdy[0]), .mux_sel(sel[0]), .data_bit(dbit[0]),
      .parity_bit(pbit[0]), .tx_busy(busy[0]), .tx_done(done[0]));

   uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_W(D), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(rdy[1]), .mux_sel(sel[1]), .data_bit(dbit[1]),
      .parity_bit(pbit[1]), .tx_busy(busy[1]), .tx_done(done[1]));

   uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_W(D), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(rdy[2]), .mux_sel(sel[2]), .data_bit(dbit[2]),
      .parity_bit(pbit[2]), .tx_busy(busy[2]), .tx_done(done[2]));

   // Reference model: a frame is a run of L = (2 + D + en) * C cycles starting
   // the cycle after accept; the bit slot is (k-1)/C for cycle offset k.
   int         en  [3] = '{1, 1, 0};
   int         odd [3] = '{0, 1, 0};
   bit         act [3] = '{0, 0, 0};
   bit         rdy_m [3] = '{0, 0, 0};
   int         acc [3];
   logic [7:0] byt [3];
   logic       ph  [3] = '{1'b0, 1'b0, 1'b0};
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic check(input string tag, input int i, input logic [7:0] obs,
                        input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h",
                tag, i, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         int len;
         len = (2 + D + en[i]) * C;
         if (!rst_n) begin
            act[i] = 1'b0;
            ph[i]  = 1'b0;
         end else if (rdy_m[i] && tx_valid) begin
            act[i] = 1'b1;
            acc[i] = cyc;
            byt[i] = tx_data;
            ph[i]  = (^tx_data) ^ (odd[i] != 0);
         end else if (act[i] && (cyc - acc[i] + 1 > len)) begin
            act[i] = 1'b0;
         end
         rdy_m[i] = !act[i];
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         int         len, k, slot;
         logic [1:0] e_sel;
         logic       e_db, e_done;
         len    = (2 + D + en[i]) * C;
         e_sel  = 2'b00;
         e_db   = 1'b0;
         e_done = 1'b0;
         if (act[i]) begin
            k    = cyc - acc[i] + 1;
            slot = (k - 1) / C;
            if (slot == 0) begin
               e_sel = 2'b01;
               e_db  = byt[i][0];
            end else if (slot <= D) begin
               e_sel = 2'b10;
               e_db  = byt[i][slot-1];
            end else if ((slot == D + 1) && (en[i] != 0)) begin
               e_sel = 2'b11;
            end
            e_done = (k == len);
         end
         check("mux_sel",    i, {6'd0, sel[i]}, {6'd0, e_sel});
         check("tx_ready",   i, {7'd0, rdy[i]},  {7'd0, !act[i]});
         check("tx_busy",    i, {7'd0, busy[i]}, {7'd0, act[i]});
         check("tx_done",    i, {7'd0, done[i]}, {7'd0, e_done});
         check("data_bit",   i, {7'd0, dbit[i]}, {7'd0, e_db});
         check("parity_bit", i, {7'd0, pbit[i]}, {7'd0, ph[i]});
      end
   endtask

   task automatic run(input int n);
      for (int j = 0; j < n; j++) begin
         step();
         tx_data = 8'($urandom);
      end
   endtask

   task automatic send(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      step();
      step();
      tx_valid = 1'b0;
      rst_n    = 1'b1;
      step();

      send(8'hA5);
      run(180);
      send(8'h01);
      run(180);
      send(8'hFF);
      run(180);

      // back-to-back with valid held
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      step();
      tx_data  = 8'hC3;
      for (int j = 0; j < 360; j++) step();
      tx_valid = 1'b0;
      run(200);

      // reset during the data phase, then a fresh frame
      send(8'($urandom));
      run(49);
      rst_n = 1'b0;
      tx_valid = 1'b1;
      step();
      rst_n = 1'b1;
      tx_valid = 1'b0;
      step();
      send(8'h96);
      run(180);

      // random traffic with occasional resets
      for (int j = 0; j < 1800; j++) begin
         tx_valid = ($urandom_range(0, 3) == 0);
         tx_data  = 8'($urandom);
         rst_n    = ($urandom_range(0, 299) != 0);
         step();
      end
      rst_n    = 1'b1;
      tx_valid = 1'b0;
      run(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
